// File: rtl/wgen_seq.sv
// -----------------------------------------------------------------------------
// wgen_seq -- sequential round-constant generator for the masked Clyde datapath.
//
// Holds the round constant W in a register that the round controller advances
// one update per accepted step. A sequence is opened with start (direction
// taken from decrypt). Encryption walks W forward from INIT. Decryption loads
// WFINAL, the value reached after NSTEPS forward updates, and walks it back to
// INIT with the inverse map.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   start     in   open a new sequence (honoured in IDLE only)
//   decrypt   in   direction, sampled with start: 0 forward, 1 inverse
//   step      in   advance W (honoured in RUN only)
//   W         out  current constant, registered
//   busy      out  high while in RUN, registered
//   done      out  one-cycle pulse in the cycle after the final step, registered
//   step_cnt  out  updates applied in the current sequence, never wraps
//
// Build option:
//   WGEN_DOUBLE_STEP_EN -- each accepted step applies the selected map twice
//   and advances step_cnt by 2 (NSTEPS must then be even). WFINAL is the same
//   in both builds.
// -----------------------------------------------------------------------------
module wgen_seq #(
  parameter int               WIDTH  = 4,
  parameter logic [WIDTH-1:0] POLY   = 4'b0011,
  parameter logic [WIDTH-1:0] INIT   = 4'b0001,
  parameter int               NSTEPS = 12,
  parameter int               CW     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             decrypt,
  input  logic             step,
  output logic [WIDTH-1:0] W,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    step_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Forward map: shift left, fold the outgoing MSB back in through the taps.
  function automatic logic [WIDTH-1:0] fwd_map(input logic [WIDTH-1:0] w);
    fwd_map = {w[WIDTH-2:0], 1'b0} ^ (w[WIDTH-1] ? POLY : '0);
  endfunction

  // Inverse map: POLY[0]=1 means bit 0 of the result reveals whether the
  // taps were applied, so undo them first and restore the lost MSB.
  function automatic logic [WIDTH-1:0] inv_map(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] t;
    if (w[0]) begin
      t       = w ^ POLY;
      inv_map = {1'b1, t[WIDTH-1:1]};
    end else begin
      inv_map = {1'b0, w[WIDTH-1:1]};
    end
  endfunction

  function automatic logic [WIDTH-1:0] calc_final();
    logic [WIDTH-1:0] w;
    w = INIT;
    for (int i = 0; i < NSTEPS; i++) begin
      w = fwd_map(w);
    end
    calc_final = w;
  endfunction

  localparam logic [WIDTH-1:0] WFINAL   = calc_final();
  localparam logic [CW-1:0]    NSTEPS_C = CW'(NSTEPS);

`ifdef WGEN_DOUBLE_STEP_EN
  localparam logic [CW-1:0] STEP_INC = CW'(2);

  function automatic logic [WIDTH-1:0] step_map(input logic [WIDTH-1:0] w,
                                                input logic             inv);
    step_map = inv ? inv_map(inv_map(w)) : fwd_map(fwd_map(w));
  endfunction

  if ((NSTEPS % 2) != 0) begin : g_bad_nsteps
    $error("wgen_seq: NSTEPS must be even when double stepping");
  end
`else
  localparam logic [CW-1:0] STEP_INC = CW'(1);

  function automatic logic [WIDTH-1:0] step_map(input logic [WIDTH-1:0] w,
                                                input logic             inv);
    step_map = inv ? inv_map(w) : fwd_map(w);
  endfunction
`endif

  if ((1 << CW) <= NSTEPS) begin : g_bad_cw
    $error("wgen_seq: CW too narrow to hold NSTEPS");
  end

  if (POLY[0] != 1'b1) begin : g_bad_poly
    $error("wgen_seq: POLY[0] must be 1 for the map to be invertible");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] w_q,     w_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             dir_q,   dir_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  always_comb begin
    // NOTE: every signal gets its hold value before the case, so no path
    // through the decode leaves one unassigned and no latch is inferred.
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;

    unique case (state_q)
      IDLE: begin
        // start wins over a simultaneous step; step is simply not decoded here.
        if (start) begin
          w_d     = decrypt ? WFINAL : INIT;
          dir_d   = decrypt;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (step) begin
          w_d   = step_map(w_q, dir_q);
          cnt_d = cnt_q + STEP_INC;
          if (cnt_d == NSTEPS_C) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flag outputs follow the state being entered so they are registered.
    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and covers every flop, so W and the
    // direction are well defined even if rst lands mid-sequence.
    if (rst) begin
      state_q <= IDLE;
      w_q     <= INIT;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign W        = w_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_cnt = cnt_q;

endmodule

// File: tb/tb_wgen_seq.sv
// -----------------------------------------------------------------------------
// tb_wgen_seq -- self-checking bench for wgen_seq (default parameters).
// Fixed scenarios compare against the literal W sequences of the constant
// schedule; a random phase compares every cycle against a behavioural model
// that derives the inverse map by searching the forward map.
// Honours WGEN_DOUBLE_STEP_EN when the same define is given to the build.
// -----------------------------------------------------------------------------
module tb_wgen_seq;

`ifdef WGEN_DOUBLE_STEP_EN
  localparam int K = 2;
  localparam int NCALLS = 6;
  logic [3:0] fwd_exp [7]  = '{4'h1, 4'h4, 4'h3, 4'hC, 4'h5, 4'h7, 4'hF};
  logic [3:0] inv_exp [7]  = '{4'hF, 4'h7, 4'h5, 4'hC, 4'h3, 4'h4, 4'h1};
  localparam int RST_AT = 3;
`else
  localparam int K = 1;
  localparam int NCALLS = 12;
  logic [3:0] fwd_exp [13] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC,
                               4'hB, 4'h5, 4'hA, 4'h7, 4'hE, 4'hF};
  logic [3:0] inv_exp [13] = '{4'hF, 4'hE, 4'h7, 4'hA, 4'h5, 4'hB, 4'hC,
                               4'h6, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1};
  localparam int RST_AT = 7;
`endif

  localparam int POLY_I = 3;
  localparam int INIT_I = 1;
  localparam int NSTEPS = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       decrypt = 1'b0;
  logic       step = 1'b0;
  logic [3:0] W;
  logic       busy;
  logic       done;
  logic [3:0] step_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: phase 0 idle, 1 running, 2 finishing.
  int         m_phase = 0;
  logic [3:0] m_w     = 4'(INIT_I);
  int         m_cnt   = 0;
  bit         m_dir   = 1'b0;
  logic [3:0] m_final;

  wgen_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .decrypt  (decrypt),
    .step     (step),
    .W        (W),
    .busy     (busy),
    .done     (done),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] m_fwd(input logic [3:0] w);
    int v;
    v = int'(w) * 2;
    if (v >= 16) v = (v - 16) ^ POLY_I;
    return 4'(v);
  endfunction

  function automatic logic [3:0] m_inv(input logic [3:0] w);
    for (int x = 0; x < 16; x++) begin
      if (m_fwd(4'(x)) == w) return 4'(x);
    end
    return 4'h0;
  endfunction

  task automatic model_edge(input logic r, input logic s, input logic d,
                            input logic st);
    if (r) begin
      m_phase = 0; m_w = 4'(INIT_I); m_cnt = 0; m_dir = 1'b0;
    end else if (m_phase == 0) begin
      if (s) begin
        m_w = d ? m_final : 4'(INIT_I); m_dir = d; m_cnt = 0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (st) begin
        for (int k = 0; k < K; k++) m_w = m_dir ? m_inv(m_w) : m_fwd(m_w);
        m_cnt += K;
        if (m_cnt == NSTEPS) m_phase = 2;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  // Drive one cycle of inputs, advance DUT and model, settle past the edge.
  task automatic tick(input logic r, input logic s, input logic d,
                      input logic st);
    rst = r; start = s; decrypt = d; step = st;
    @(posedge clk);
    model_edge(r, s, d, st);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0);
      n_cmp++;
      if ({W, busy, done, step_cnt} !== {4'h1, 1'b0, 1'b0, 4'h0}) begin
        n_err++;
        $display("FAIL reset_idle cyc%0d: W=%h busy=%b done=%b cnt=%0d, want W=1 busy=0 done=0 cnt=0",
                 i, W, busy, done, step_cnt);
      end
    end
  endtask

  task automatic test_sequence(input bit inv);
    int dones;
    logic [3:0] want;
    dones = 0;
    tick(0, 1, inv, 0);
    want = inv ? inv_exp[0] : fwd_exp[0];
    n_cmp++;
    if ({W, busy, step_cnt} !== {want, 1'b1, 4'h0}) begin
      n_err++;
      $display("FAIL seq%0d_load: W=%h busy=%b cnt=%0d, want W=%h busy=1 cnt=0",
               inv, W, busy, step_cnt, want);
    end
    for (int i = 1; i <= NCALLS; i++) begin
      tick(0, 0, 0, 1);
      want = inv ? inv_exp[i] : fwd_exp[i];
      if (done) dones++;
      n_cmp++;
      if ({W, step_cnt, done, busy} !== {want, 4'(i * K), i == NCALLS, i != NCALLS}) begin
        n_err++;
        $display("FAIL seq%0d_step%0d: W=%h cnt=%0d done=%b busy=%b, want W=%h cnt=%0d done=%b busy=%b",
                 inv, i, W, step_cnt, done, busy, want, i * K, i == NCALLS, i != NCALLS);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1);
      if (done) dones++;
    end
    n_cmp++;
    if ({W, busy, dones} !== {want, 1'b0, 32'd1}) begin
      n_err++;
      $display("FAIL seq%0d_end: W=%h busy=%b done_pulses=%0d, want W=%h busy=0 done_pulses=1",
               inv, W, busy, dones, want);
    end
  endtask

  task automatic test_gaps_and_ignored();
    tick(0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) tick(0, 0, 0, 1);
    for (int g = 0; g < 3; g++) begin
      tick(0, (g == 1), 1, 0);  // a start in the gap must be ignored
      n_cmp++;
      if ({W, step_cnt, busy} !== {fwd_exp[4], 4'(4 * K), 1'b1}) begin
        n_err++;
        $display("FAIL gap%0d: W=%h cnt=%0d busy=%b, want W=%h cnt=%0d busy=1",
                 g, W, step_cnt, busy, fwd_exp[4], 4 * K);
      end
    end
    for (int i = 5; i <= NCALLS; i++) begin
      tick(0, (i == 6), 1, 1);  // start alongside a step, still ignored
      n_cmp++;
      if (W !== fwd_exp[i]) begin
        n_err++;
        $display("FAIL gap_resume%0d: W=%h, want %h", i, W, fwd_exp[i]);
      end
    end
    tick(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1);  // step in IDLE
      n_cmp++;
      if ({W, step_cnt, busy, done} !== {fwd_exp[NCALLS], 4'(NSTEPS), 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL idle_step%0d: W=%h cnt=%0d busy=%b done=%b, want W=%h cnt=%0d busy=0 done=0",
                 i, W, step_cnt, busy, done, fwd_exp[NCALLS], NSTEPS);
      end
    end
    tick(0, 1, 0, 1);  // start and step together in IDLE: start wins
    n_cmp++;
    if ({W, step_cnt, busy} !== {4'h1, 4'h0, 1'b1}) begin
      n_err++;
      $display("FAIL start_step_idle: W=%h cnt=%0d busy=%b, want W=1 cnt=0 busy=1",
               W, step_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    for (int i = 1; i <= RST_AT; i++) tick(0, 0, 0, 1);
    n_cmp++;
    if (W !== fwd_exp[RST_AT]) begin
      n_err++;
      $display("FAIL rst_mid_pre: W=%h, want %h", W, fwd_exp[RST_AT]);
    end
    tick(1, 0, 0, 1);
    n_cmp++;
    if ({W, step_cnt, busy, done} !== {4'h1, 4'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_mid: W=%h cnt=%0d busy=%b done=%b, want W=1 cnt=0 busy=0 done=0",
               W, step_cnt, busy, done);
    end
    tick(0, 0, 0, 1);
    n_cmp++;
    if ({W, step_cnt, busy, done} !== {4'h1, 4'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_mid_after: W=%h cnt=%0d busy=%b done=%b, want W=1 cnt=0 busy=0 done=0",
               W, step_cnt, busy, done);
    end
  endtask

  task automatic test_random();
    logic r, s, d, st;
    for (int c = 0; c < 600; c++) begin
      r  = ($urandom_range(99) < 2);
      s  = ($urandom_range(99) < 20);
      d  = 1'($urandom);
      st = ($urandom_range(99) < 70);
      tick(r, s, d, st);
      n_cmp++;
      if ({W, busy, done, step_cnt} !==
          {m_w, m_phase == 1, m_phase == 2, 4'(m_cnt)}) begin
        n_err++;
        $display("FAIL random cyc%0d: W=%h busy=%b done=%b cnt=%0d, want W=%h busy=%b done=%b cnt=%0d",
                 c, W, busy, done, step_cnt, m_w, m_phase == 1, m_phase == 2, m_cnt);
      end
    end
  endtask

  initial begin
    m_final = 4'(INIT_I);
    for (int i = 0; i < NSTEPS; i++) m_final = m_fwd(m_final);
    test_reset();
    test_sequence(1'b0);
    test_sequence(1'b1);
    test_gaps_and_ignored();
    test_reset_mid();
    tick(1, 0, 0, 0);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
